// File: rtl/systolic_pkg.sv
// Shared types and defaults for the weight-stationary systolic array.
// Default number format is signed Q8.8 in 16 bits.
package systolic_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_FRAC_BITS = 8;

    typedef logic signed [DEF_DATA_W-1:0]   data_t;
    typedef logic signed [2*DEF_DATA_W-1:0] prod_t;

    // One fixed-point multiply-accumulate step in the default format:
    // full-width signed product, arithmetic rescale, truncate, wrapping add.
    function automatic data_t fxp_mac(input data_t psum, input data_t x, input data_t w);
        prod_t prod;
        prod_t scaled;
        prod   = prod_t'(x) * prod_t'(w);
        scaled = prod >>> DEF_FRAC_BITS;
        return psum + data_t'(scaled);
    endfunction

endpackage

// File: rtl/systolic_array_pe.sv
// Single processing element of the weight-stationary systolic array.
// Holds a shadow weight (shifted in from above) and an active weight (used
// for compute). Activations move right, psum/weight/valid/switch move down.
// Every output is registered, giving one cycle of latency per hop.
module systolic_array_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    input  logic              switch_i,
    input  logic [DATA_W-1:0] psum_i,
    input  logic [DATA_W-1:0] weight_i,
    input  logic              accept_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              switch_o,
    output logic [DATA_W-1:0] psum_o,
    output logic [DATA_W-1:0] weight_o
);

    logic [DATA_W-1:0]          data_q;
    logic                       valid_q, valid_d;
    logic                       switch_q;
    logic [DATA_W-1:0]          psum_q, psum_d;
    logic [DATA_W-1:0]          shadow_q, shadow_d;
    logic [DATA_W-1:0]          active_q, active_d;
    logic signed [DATA_W-1:0]   w_eff;
    logic signed [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]          mac_term;

    // MAC and weight bookkeeping; the vector travelling with the switch
    // wavefront already sees the freshly swapped weight, and a coincident
    // accept only affects the shadow after this edge.
    always_comb begin
        w_eff    = switch_i ? $signed(shadow_q) : $signed(active_q);
        active_d = w_eff;
        shadow_d = accept_i ? weight_i : shadow_q;
        prod     = (2*DATA_W)'($signed(data_i)) * (2*DATA_W)'(w_eff);
        mac_term = DATA_W'(prod >>> FRAC_BITS);
        psum_d   = en_i ? (psum_i + mac_term) : '0;
        valid_d  = en_i & valid_i;
    end

    // State and forwarding registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q   <= '0;
            valid_q  <= 1'b0;
            switch_q <= 1'b0;
            psum_q   <= '0;
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            data_q   <= data_i;
            valid_q  <= valid_d;
            switch_q <= switch_i;
            psum_q   <= psum_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign data_o   = data_q;
    assign valid_o  = valid_q;
    assign switch_o = switch_q;
    assign psum_o   = psum_q;
    assign weight_o = shadow_q;

endmodule

// File: rtl/systolic_array.sv
// ROWS x COLS weight-stationary systolic array with signed fixed-point MAC,
// saturating column-size decode and per-column enable mask.
// Optional macro SYSTOLIC_SKEW_EN adds internal input skew and output deskew
// so the caller presents whole vectors and all columns emerge together.
module systolic_array
    import systolic_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ROWS*DATA_W-1:0] sys_data_in,
    input  logic                   sys_start,
    input  logic [COLS*DATA_W-1:0] sys_weight_in,
    input  logic [COLS-1:0]        sys_accept_w,
    input  logic                   sys_switch_in,
    input  logic [15:0]            ub_rd_col_size_in,
    input  logic                   ub_rd_col_size_valid_in,
    output logic [COLS*DATA_W-1:0] sys_data_out,
    output logic [COLS-1:0]        sys_valid_out
);

    logic [COLS-1:0]   col_en_q, col_en_d;
    logic [DATA_W-1:0] row_data  [ROWS];
    logic [DATA_W-1:0] pe_data   [ROWS][COLS];
    logic [DATA_W-1:0] pe_psum   [ROWS][COLS];
    logic [DATA_W-1:0] pe_weight [ROWS][COLS];
    logic              pe_valid  [ROWS][COLS];
    logic              pe_switch [ROWS][COLS];

    // Column-size decode: first min(col_size, COLS) columns enabled.
    always_comb begin
        col_en_d = col_en_q;
        if (ub_rd_col_size_valid_in) begin
            for (int c = 0; c < COLS; c++) begin
                col_en_d[c] = (int'(ub_rd_col_size_in) > c);
            end
        end
    end

    // Column enable mask register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col_en_q <= '0;
        end else begin
            col_en_q <= col_en_d;
        end
    end

    // PE grid: activations enter on the left, weights and psum enter on top,
    // valid/switch run along row 0 and then down each column.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [DATA_W-1:0] data_in, psum_in, weight_in;
            logic              valid_in, switch_in;

            if (c == 0) begin : g_left
                assign data_in = row_data[r];
            end else begin : g_inner
                assign data_in = pe_data[r][c-1];
            end

            if (r == 0) begin : g_top
                assign psum_in   = '0;
                assign weight_in = sys_weight_in[c*DATA_W +: DATA_W];
                if (c == 0) begin : g_origin
                    assign valid_in  = sys_start;
                    assign switch_in = sys_switch_in;
                end else begin : g_right
                    assign valid_in  = pe_valid[0][c-1];
                    assign switch_in = pe_switch[0][c-1];
                end
            end else begin : g_below
                assign psum_in   = pe_psum[r-1][c];
                assign weight_in = pe_weight[r-1][c];
                assign valid_in  = pe_valid[r-1][c];
                assign switch_in = pe_switch[r-1][c];
            end

            systolic_array_pe #(
                .DATA_W    (DATA_W),
                .FRAC_BITS (FRAC_BITS)
            ) u_pe (
                .clk      (clk),
                .rst      (rst),
                .en_i     (col_en_q[c]),
                .data_i   (data_in),
                .valid_i  (valid_in),
                .switch_i (switch_in),
                .psum_i   (psum_in),
                .weight_i (weight_in),
                .accept_i (sys_accept_w[c]),
                .data_o   (pe_data[r][c]),
                .valid_o  (pe_valid[r][c]),
                .switch_o (pe_switch[r][c]),
                .psum_o   (pe_psum[r][c]),
                .weight_o (pe_weight[r][c])
            );
        end
    end

`ifdef SYSTOLIC_SKEW_EN
    // Input skew: row r is delayed by r registers.
    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        if (r == 0) begin : g_direct
            assign row_data[r] = sys_data_in[0 +: DATA_W];
        end else begin : g_dly
            logic [DATA_W-1:0] skew_q [r];

            // Row skew shift register.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int k = 0; k < r; k++) skew_q[k] <= '0;
                end else begin
                    skew_q[0] <= sys_data_in[r*DATA_W +: DATA_W];
                    for (int k = 1; k < r; k++) skew_q[k] <= skew_q[k-1];
                end
            end

            assign row_data[r] = skew_q[r-1];
        end
    end

    // Output deskew: column c is delayed by COLS-1-c registers.
    for (genvar c = 0; c < COLS; c++) begin : g_deskew
        localparam int DLY = COLS - 1 - c;
        if (DLY == 0) begin : g_direct
            assign sys_data_out[c*DATA_W +: DATA_W] = pe_psum[ROWS-1][c];
            assign sys_valid_out[c]                 = pe_valid[ROWS-1][c];
        end else begin : g_dly
            logic [DATA_W-1:0] deskew_data_q  [DLY];
            logic              deskew_valid_q [DLY];

            // Column deskew shift register for result and valid.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int k = 0; k < DLY; k++) begin
                        deskew_data_q[k]  <= '0;
                        deskew_valid_q[k] <= 1'b0;
                    end
                end else begin
                    deskew_data_q[0]  <= pe_psum[ROWS-1][c];
                    deskew_valid_q[0] <= pe_valid[ROWS-1][c];
                    for (int k = 1; k < DLY; k++) begin
                        deskew_data_q[k]  <= deskew_data_q[k-1];
                        deskew_valid_q[k] <= deskew_valid_q[k-1];
                    end
                end
            end

            assign sys_data_out[c*DATA_W +: DATA_W] = deskew_data_q[DLY-1];
            assign sys_valid_out[c]                 = deskew_valid_q[DLY-1];
        end
    end
`else
    // No internal skew: the caller delays row r by r cycles.
    for (genvar r = 0; r < ROWS; r++) begin : g_rows_in
        assign row_data[r] = sys_data_in[r*DATA_W +: DATA_W];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_cols_out
        assign sys_data_out[c*DATA_W +: DATA_W] = pe_psum[ROWS-1][c];
        assign sys_valid_out[c]                 = pe_valid[ROWS-1][c];
    end
`endif

endmodule
